sa_result_drain: RTL and testbench
==================================

# sa_result_drain

Result-side companion to `SA_CORE`. It watches the per-row result-valid vector and acknowledges finished results with `outread`. Acknowledged results are captured into a two-bank ping-pong buffer, then serialized one 32-bit word per beat onto a valid/ready stream for the output memory or host interface. The drain holds off the acknowledge until a bank is free, so no result is ever dropped.

## Interface
- `ROWS`, default 8: number of systolic rows and width of the valid vector.
- `RW`, default `$clog2(ROWS)`: width of the row index on the output stream.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rstn`  in  1: asynchronous, active-low reset.
- `routport`  in  32 x [0:ROWS-1]: per-row accumulated results from `SA_CORE`.
- `rvalidport`  in  [0:ROWS-1]: element r high means `routport[r]` holds an unread result.
- `outread`  out  1: acknowledge to `SA_CORE`; one-cycle pulse per capture.
- `m_valid`  out  1: output word valid.
- `m_ready`  in  1: downstream accepts the word.
- `m_data`  out  32: result word.
- `m_row`  out  RW: source row of `m_data`.
- `m_last`  out  1: last word of the current bank.
- `busy`  out  1: at least one bank is full.

## Operation
- Storage: banks B0 and B1. Each bank holds `data[ROWS]` (32-bit), `mask[ROWS]` and a `full` flag. Write pointer `wp` and read pointer `rp` are 1 bit each.
- Capture condition, all evaluated on pre-edge values: `rvalidport != 0`, `outread == 0`, and `bank[wp].full == 0`.
- On a capture edge:
  - for every r with `rvalidport[r]`, `data[r] <= routport[r]`
  - `mask <= rvalidport`, `full <= 1`
  - `wp` toggles
  - registered `outread <= 1`
- `outread` falls on the following edge, so each capture produces exactly one high cycle.
- No capture is possible while `outread` is high. `SA_CORE` drops the acknowledged `rvalidport` bits on the edge where it samples `outread`.
- Drain: while `bank[rp].full`, the outputs are driven from registered state:
  - `m_valid = 1`
  - `m_row` = lowest r with `mask[r]` set
  - `m_data = data[m_row]`
  - `m_last` = 1 when no higher mask bit is set
- On an edge with `m_valid & m_ready`:
  - clear `mask[m_row]`
  - if `m_last`: `full <= 0` and `rp` toggles
- Rows whose mask bit is 0 are skipped and never emitted. Word order within a bank is ascending row index. Banks are emitted in capture order.
- While `m_valid` is high and `m_ready` is low, `m_data`, `m_row` and `m_last` stay stable.
- `busy = B0.full | B1.full`.
- Simultaneous capture and free in one cycle:
  - capture into `bank[wp]` and free of `bank[rp]` on the same edge are legal, because they are different banks whenever both are active
  - if both banks are full, capture is blocked on that edge even if a bank frees on it; the capture happens on the next edge
- Data is copied bit-exact; there is no arithmetic, truncation or sign handling.

## Timing
- Reset (async assert) clears `outread`, `m_valid`, `m_data`, `m_row`, `m_last`, `busy`, both masks and `full` flags, `wp` and `rp` to 0 immediately, mid-transfer included. Partially drained words are discarded.
- Capture edge N: `outread` is high for cycle N→N+1, and the first `m_valid` appears in the same cycle if `rp` points at the captured bank.
- A bank holding k set mask bits drains in k cycles at `m_ready = 1`. Sustained throughput is 1 word/cycle.
- Minimum spacing between captures is 2 cycles because of `outread` masking.
- `rvalidport` high while both banks are full leaves `outread` low indefinitely. No overflow state exists.

## Test plan
- Reset:
  - hold `rstn` low with `rvalidport = 8'hFF` → `outread`, `m_valid` and `busy` stay 0
  - release `rstn` → first capture on the next edge.
- Full bank, `ROWS = 8`, `routport[r] = 100*r`, all valid, `m_ready = 1`:
  - one `outread` pulse
  - 8 beats with rows 0..7, data 0,100,…,700
  - `m_last` only on row 7, `busy` low after the last beat.
- Sparse bank, valid rows {0,2,7} with data 5, 9, 42:
  - exactly 3 beats, in order (0,5), (2,9), (7,42)
  - `m_last` on row 7.
- Backpressure, `m_ready = 0`, three result sets presented back-to-back:
  - two captures and two `outread` pulses, then `outread` stays low with `busy = 1` and `m_data` stable
  - raise `m_ready` → bank 0 drains, the third set is captured on the edge after B0 frees, and order is preserved.
- Capture/free overlap: time a new `rvalidport` so it arrives on the same edge as B0's `m_last` handshake while B1 is empty → the capture into B1 occurs on that edge with no lost beat.
- Reset mid-drain, asserted after the 3rd of 8 beats:
  - `m_valid` drops at once
  - after release, no stale words are emitted and the next capture starts at B0, row 0.

Source files
------------

// File: rtl/sa_result_drain_if.sv
// Output stream of the systolic result drain: one 32-bit word per beat,
// tagged with its source row and an end-of-bank marker.
interface sa_result_drain_if #(
  parameter int unsigned RW = 3
);
  logic          m_valid;
  logic          m_ready;
  logic [31:0]   m_data;
  logic [RW-1:0] m_row;
  logic          m_last;

  modport master (output m_valid, m_data, m_row, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_row, m_last, output m_ready);
endinterface

// File: rtl/sa_result_drain.sv
// Result drain for SA_CORE: acknowledges finished row results into a two-bank
// ping-pong buffer and serializes them one word per beat onto a valid/ready stream.
module sa_result_drain #(
  parameter int unsigned ROWS = 8,
  parameter int unsigned RW   = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [31:0]       routport [ROWS],
  input  logic [0:ROWS-1]   rvalidport,
  output logic              outread,
  output logic              busy,
  sa_result_drain_if.master m
);
  localparam int unsigned DW = 32;
  localparam int unsigned NB = 2;

  logic [DW-1:0]   data_q [NB][ROWS];
  logic [0:ROWS-1] mask_q [NB];
  logic [0:ROWS-1] mask_d [NB];
  logic [NB-1:0]   full_q, full_d;
  logic            wp_q, wp_d;
  logic            rp_q, rp_d;
  logic            outread_q;
  logic            busy_q, busy_d;
  logic            m_valid_q, m_valid_d;
  logic [DW-1:0]   m_data_q, m_data_d;
  logic [RW-1:0]   m_row_q, m_row_d;
  logic            m_last_q, m_last_d;
  logic            cap_c, hs_c, sel_found;

  // Bank bookkeeping; capture and free never target the same bank on one edge.
  always_comb begin
    cap_c  = (|rvalidport) && !outread_q && !full_q[wp_q];
    hs_c   = m_valid_q && m.m_ready;
    mask_d = mask_q;
    full_d = full_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    if (hs_c) begin
      mask_d[rp_q][m_row_q] = 1'b0;
      if (m_last_q) begin
        full_d[rp_q] = 1'b0;
        rp_d         = ~rp_q;
      end
    end
    if (cap_c) begin
      mask_d[wp_q] = rvalidport;
      full_d[wp_q] = 1'b1;
      wp_d         = ~wp_q;
    end
  end

  // Next output word: lowest pending row of the read bank; data bypasses the
  // bank array when that bank is being filled on this very edge.
  always_comb begin
    m_valid_d = full_d[rp_d];
    m_row_d   = '0;
    m_last_d  = 1'b0;
    m_data_d  = '0;
    sel_found = 1'b0;
    if (m_valid_d) begin
      m_last_d = 1'b1;
      for (int unsigned r = 0; r < ROWS; r++) begin
        if (mask_d[rp_d][r]) begin
          if (!sel_found) begin
            sel_found = 1'b1;
            m_row_d   = RW'(r);
          end else begin
            m_last_d = 1'b0;
          end
        end
      end
      m_data_d = (cap_c && (rp_d == wp_q)) ? routport[m_row_d] : data_q[rp_d][m_row_d];
    end
    busy_d = |full_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mask_q    <= '{default: '0};
      full_q    <= '0;
      wp_q      <= 1'b0;
      rp_q      <= 1'b0;
      outread_q <= 1'b0;
      busy_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_row_q   <= '0;
      m_last_q  <= 1'b0;
    end else begin
      mask_q    <= mask_d;
      full_q    <= full_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      outread_q <= cap_c;
      busy_q    <= busy_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_row_q   <= m_row_d;
      m_last_q  <= m_last_d;
    end
  end

  // Payload storage needs no reset: the mask gates every read.
  always_ff @(posedge clk) begin
    if (cap_c) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        if (rvalidport[r]) data_q[wp_q][r] <= routport[r];
      end
    end
  end

  assign outread   = outread_q;
  assign busy      = busy_q;
  assign m.m_valid = m_valid_q;
  assign m.m_data  = m_data_q;
  assign m.m_row   = m_row_q;
  assign m.m_last  = m_last_q;
endmodule

// File: tb/tb_sa_result_drain.sv
// Scoreboard bench for sa_result_drain: directed result sets push expected beats,
// a monitor pops and compares every accepted output word.
module tb_sa_result_drain;
  localparam int unsigned ROWS = 8;
  localparam int unsigned RW   = 3;

  typedef struct packed {
    logic [RW-1:0] row;
    logic [31:0]   data;
    logic          last;
  } beat_t;

  logic            clk  = 1'b0;
  logic            rstn = 1'b0;
  logic [31:0]     routport [ROWS];
  logic [0:ROWS-1] rvalidport;
  logic            outread;
  logic            busy;

  sa_result_drain_if #(.RW(RW)) m_if ();

  sa_result_drain #(.ROWS(ROWS), .RW(RW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .routport   (routport),
    .rvalidport (rvalidport),
    .outread    (outread),
    .busy       (busy),
    .m          (m_if.master)
  );

  always #5 clk = ~clk;

  beat_t       exp_q[$];
  int          total  = 0;
  int          bad    = 0;
  int          popped = 0;
  logic [31:0] vec [ROWS];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Present vec[] under mask msk and queue the words that must come out.
  task automatic drive_set(input logic [0:ROWS-1] msk);
    int    hi;
    beat_t b;
    hi = -1;
    for (int r = 0; r < int'(ROWS); r++) if (msk[r]) hi = r;
    for (int r = 0; r < int'(ROWS); r++) begin
      routport[r] = vec[r];
      if (msk[r]) begin
        b.row  = RW'(r);
        b.data = vec[r];
        b.last = (r == hi);
        exp_q.push_back(b);
      end
    end
    rvalidport = msk;
  endtask

  // Acts as SA_CORE: waits for the acknowledge, then withdraws the valid bits.
  task automatic wait_ack(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if (outread) begin
        cyc        = i;
        rvalidport = '0;
        break;
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain_complete", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic monitor();
    logic  stall;
    beat_t held, got, want;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      got.row  = m_if.m_row;
      got.data = m_if.m_data;
      got.last = m_if.m_last;
      if (rstn && m_if.m_valid && stall) chk("stall_stable", 64'(got), 64'(held));
      if (rstn && m_if.m_valid && m_if.m_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got row %0d data 0x%0h, want no beat", got.row, got.data);
        end else begin
          want = exp_q.pop_front();
          chk("beat_row",  64'(got.row),  64'(want.row));
          chk("beat_data", 64'(got.data), 64'(want.data));
          chk("beat_last", 64'(got.last), 64'(want.last));
        end
        popped++;
      end
      stall = rstn && m_if.m_valid && !m_if.m_ready;
      held  = got;
    end
  endtask

  task automatic run();
    int              cyc;
    int              base;
    logic [0:ROWS-1] msk;

    // Reset with every row valid: nothing may be acknowledged or emitted.
    m_if.m_ready = 1'b1;
    for (int r = 0; r < int'(ROWS); r++) vec[r] = 32'(100 * r);
    drive_set('1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_outread", 64'(outread), 64'(0));
      chk("rst_m_valid", 64'(m_if.m_valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
    end
    @(negedge clk);
    rstn = 1'b1;
    wait_ack(1, cyc);
    chk("full_capture_cycle", 64'(cyc), 64'(1));
    chk("full_first_valid", 64'(m_if.m_valid), 64'(1));
    chk("full_first_row", 64'(m_if.m_row), 64'(0));
    chk("full_busy", 64'(busy), 64'(1));
    @(posedge clk); #1;
    chk("full_outread_fall", 64'(outread), 64'(0));
    wait_drain(20);
    chk("full_busy_after", 64'(busy), 64'(0));
    chk("full_valid_after", 64'(m_if.m_valid), 64'(0));

    // Sparse bank: only rows 0, 2, 7 may appear.
    for (int r = 0; r < int'(ROWS); r++) vec[r] = 32'hDEAD_0000 | 32'(r);
    vec[0] = 32'd5; vec[2] = 32'd9; vec[7] = 32'd42;
    msk = '0; msk[0] = 1'b1; msk[2] = 1'b1; msk[7] = 1'b1;
    drive_set(msk);
    wait_ack(3, cyc);
    chk("sparse_capture_cycle", 64'(cyc), 64'(1));
    @(posedge clk); #1;
    chk("sparse_outread_fall", 64'(outread), 64'(0));
    wait_drain(20);
    chk("sparse_busy_after", 64'(busy), 64'(0));

    // Backpressure: two sets fill both banks, the third must wait.
    m_if.m_ready = 1'b0;
    for (int r = 0; r < int'(ROWS); r++) vec[r] = 32'(1000 + r);
    drive_set('1);
    wait_ack(3, cyc);
    chk("bp_a_capture_cycle", 64'(cyc), 64'(1));
    for (int r = 0; r < int'(ROWS); r++) vec[r] = 32'(2000 + r);
    msk = '0; msk[1] = 1'b1; msk[3] = 1'b1;
    drive_set(msk);
    wait_ack(4, cyc);
    chk("bp_b_capture_spacing", 64'(cyc), 64'(2));
    for (int r = 0; r < int'(ROWS); r++) vec[r] = 32'(3000 + r);
    msk = '0; msk[0] = 1'b1; msk[5] = 1'b1;
    drive_set(msk);
    repeat (6) begin
      @(posedge clk); #1;
      chk("bp_outread_held", 64'(outread), 64'(0));
      chk("bp_busy", 64'(busy), 64'(1));
      chk("bp_head_data", 64'(m_if.m_data), 64'(1000));
    end
    m_if.m_ready = 1'b1;
    wait_ack(20, cyc);
    chk("bp_c_capture_cycle", 64'(cyc), 64'(9));
    chk("bp_c_pending", 64'(exp_q.size()), 64'(3));
    wait_drain(20);
    chk("bp_busy_after", 64'(busy), 64'(0));

    // Reset after three beats of a full bank discards the rest.
    for (int r = 0; r < int'(ROWS); r++) vec[r] = 32'(7000 + r);
    base = popped;
    drive_set('1);
    wait_ack(3, cyc);
    chk("mid_capture_cycle", 64'(cyc), 64'(1));
    for (int i = 0; i < 20; i++) begin
      if (popped >= base + 3) break;
      @(posedge clk); #1;
    end
    chk("mid_beats_before_reset", 64'(popped - base), 64'(3));
    chk("mid_pending", 64'(exp_q.size()), 64'(5));
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_m_valid", 64'(m_if.m_valid), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_m_data", 64'(m_if.m_data), 64'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("post_rst_no_stale", 64'(m_if.m_valid), 64'(0));
    end

    // Capture into B1 on the same edge B0 hands off its last word.
    for (int r = 0; r < int'(ROWS); r++) vec[r] = 32'(500 + r);
    msk = '0; msk[0] = 1'b1; msk[1] = 1'b1; msk[2] = 1'b1;
    drive_set(msk);
    wait_ack(2, cyc);
    chk("ovl_e_capture_cycle", 64'(cyc), 64'(1));
    chk("ovl_e_first_row", 64'(m_if.m_row), 64'(0));
    chk("ovl_e_first_data", 64'(m_if.m_data), 64'(500));
    @(posedge clk); #1;
    chk("ovl_outread_fall", 64'(outread), 64'(0));
    @(posedge clk); #1;
    chk("ovl_e_last_row", 64'(m_if.m_row), 64'(2));
    chk("ovl_e_last_flag", 64'(m_if.m_last), 64'(1));
    for (int r = 0; r < int'(ROWS); r++) vec[r] = 32'(600 + r);
    msk = '0; msk[4] = 1'b1; msk[6] = 1'b1;
    drive_set(msk);
    wait_ack(2, cyc);
    chk("ovl_f_capture_cycle", 64'(cyc), 64'(1));
    chk("ovl_f_pending", 64'(exp_q.size()), 64'(2));
    chk("ovl_f_valid", 64'(m_if.m_valid), 64'(1));
    chk("ovl_f_row", 64'(m_if.m_row), 64'(4));
    chk("ovl_f_data", 64'(m_if.m_data), 64'(604));
    chk("ovl_busy", 64'(busy), 64'(1));
    wait_drain(20);
    chk("ovl_busy_after", 64'(busy), 64'(0));
    repeat (2) @(posedge clk);
  endtask

  initial begin
    rvalidport   = '0;
    m_if.m_ready = 1'b0;
    for (int r = 0; r < int'(ROWS); r++) routport[r] = '0;
    fork
      monitor();
      run();
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
